// File: rtl/tcdm_bank_adapter.sv
// tcdm_bank_adapter: sits between the crossbar's bank port and a single-port
// SRAM with 1-cycle read latency. A request is granted only when a response
// slot is guaranteed, so the requester can stall responses without losing
// SRAM read data. Each accepted request yields exactly one in-order response.
//
// Response channel handshake: a response transfers on a cycle where
// rsp_valid_o and rsp_ready_i are both 1. Once rsp_valid_o rises it stays
// high, with rsp_rdata_o held stable, until that transfer happens; the
// requester may hold rsp_ready_i low for any number of cycles.
module tcdm_bank_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned RespDepth = 2,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 wen_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 gnt_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam logic [CntW:0]   DepthOcc = (CntW + 1)'(RespDepth);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(RespDepth - 1);

  logic [CntW-1:0]      fifo_count_q, fifo_count_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_is_write_q, inflight_is_write_d;
  logic [DataWidth-1:0] fifo_mem_q [RespDepth];
  logic [DataWidth-1:0] fifo_mem_d [RespDepth];

  logic [CntW:0]        occupancy;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [DataWidth-1:0] inflight_data;

  // Grant only when a response slot is free; a same-cycle pop is ignored
  // on purpose so the grant never depends on rsp_ready_i.
  always_comb begin
    occupancy     = {1'b0, fifo_count_q} + {{CntW{1'b0}}, inflight_q};
    fifo_empty    = (fifo_count_q == '0);
    gnt_o         = req_i & rst_ni & (occupancy < DepthOcc);
    inflight_data = inflight_is_write_q ? '0 : sram_rdata_i;
    // An in-flight response bypasses the FIFO only if it is consumed at once.
    push          = inflight_q & ~(fifo_empty & rsp_ready_i);
    pop           = ~fifo_empty & rsp_ready_i;
  end

  // SRAM is driven straight from the request; the strobe is the grant.
  always_comb begin
    sram_req_o   = gnt_o;
    sram_we_o    = wen_i;
    sram_addr_o  = addr_i;
    sram_wdata_o = wdata_i;
    sram_be_o    = be_i;
  end

  // Response side: FIFO head first, otherwise fall through the in-flight data.
  always_comb begin
    rsp_valid_o = rst_ni & (~fifo_empty | inflight_q);
    if (!fifo_empty) begin
      rsp_rdata_o = fifo_mem_q[rd_ptr_q];
    end else if (inflight_q) begin
      rsp_rdata_o = inflight_data;
    end else begin
      rsp_rdata_o = '0;
    end
  end

  // Next-state for the accept register, FIFO pointers, count and storage.
  always_comb begin
    inflight_d          = gnt_o;
    inflight_is_write_d = gnt_o ? wen_i : inflight_is_write_q;
    fifo_count_d        = fifo_count_q;
    wr_ptr_d            = wr_ptr_q;
    rd_ptr_d            = rd_ptr_q;
    fifo_mem_d          = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = inflight_data;
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CntW'(1);
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - CntW'(1);
    end
  end

  // Control state clears on reset; queued and in-flight responses are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo_count_q        <= '0;
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      inflight_q          <= 1'b0;
      inflight_is_write_q <= 1'b0;
    end else begin
      fifo_count_q        <= fifo_count_d;
      wr_ptr_q            <= wr_ptr_d;
      rd_ptr_q            <= rd_ptr_d;
      inflight_q          <= inflight_d;
      inflight_is_write_q <= inflight_is_write_d;
    end
  end

  // Response storage needs no reset: an entry is only read after being pushed.
  always_ff @(posedge clk_i) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Bench for tcdm_bank_adapter: lane a uses RespDepth=2, lane b RespDepth=3.
module tb_tcdm_bank_adapter;

  localparam int DW = 32;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- lane a signals ----------------
  logic          rst_a, req_a, wen_a, gnt_a, rsp_valid_a, rsp_ready_a;
  logic [AW-1:0] addr_a, sram_addr_a;
  logic [DW-1:0] wdata_a, rsp_rdata_a, sram_wdata_a, sram_rdata_a;
  logic [3:0]    be_a, sram_be_a;
  logic          sram_req_a, sram_we_a;
  logic [DW-1:0] mem_a [1024];

  // ---------------- lane b signals ----------------
  logic          rst_b, req_b, wen_b, gnt_b, rsp_valid_b, rsp_ready_b;
  logic [AW-1:0] addr_b, sram_addr_b;
  logic [DW-1:0] wdata_b, rsp_rdata_b, sram_wdata_b, sram_rdata_b;
  logic [3:0]    be_b, sram_be_b;
  logic          sram_req_b, sram_we_b;
  logic [DW-1:0] mem_b [1024];

  tcdm_bank_adapter #(.NumWords(1024), .RespDepth(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .req_i(req_a), .addr_i(addr_a), .wen_i(wen_a),
    .wdata_i(wdata_a), .be_i(be_a), .gnt_o(gnt_a), .rsp_valid_o(rsp_valid_a),
    .rsp_ready_i(rsp_ready_a), .rsp_rdata_o(rsp_rdata_a), .sram_req_o(sram_req_a),
    .sram_we_o(sram_we_a), .sram_addr_o(sram_addr_a), .sram_wdata_o(sram_wdata_a),
    .sram_be_o(sram_be_a), .sram_rdata_i(sram_rdata_a)
  );

  tcdm_bank_adapter #(.NumWords(1024), .RespDepth(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b), .req_i(req_b), .addr_i(addr_b), .wen_i(wen_b),
    .wdata_i(wdata_b), .be_i(be_b), .gnt_o(gnt_b), .rsp_valid_o(rsp_valid_b),
    .rsp_ready_i(rsp_ready_b), .rsp_rdata_o(rsp_rdata_b), .sram_req_o(sram_req_b),
    .sram_we_o(sram_we_b), .sram_addr_o(sram_addr_b), .sram_wdata_o(sram_wdata_b),
    .sram_be_o(sram_be_b), .sram_rdata_i(sram_rdata_b)
  );

  // Initial bank contents: word 5 and word 3 are special, the rest a pattern.
  function automatic logic [DW-1:0] exp_init(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 3) return 32'hFFFFFFFF;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // ---------------- SRAM models (1-cycle read latency) ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = exp_init(i);
      mem_b[i] = exp_init(i);
    end
    sram_rdata_a = '0;
    sram_rdata_b = '0;
  end

  always @(posedge clk) begin
    if (sram_req_a) begin
      if (sram_we_a) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_a[b]) mem_a[sram_addr_a][8*b +: 8] <= sram_wdata_a[8*b +: 8];
      end else begin
        sram_rdata_a <= mem_a[sram_addr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (sram_req_b) begin
      if (sram_we_b) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_b[b]) mem_b[sram_addr_b][8*b +: 8] <= sram_wdata_b[8*b +: 8];
      end else begin
        sram_rdata_b <= mem_b[sram_addr_b];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            gcnt [2];
  logic          prev_hold [2];
  logic [DW-1:0] prev_d [2];
  logic          rand_rdy = 1'b0;

  task automatic chk(input string name, input int k, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: grant rule, valid tracking, stability while stalled, data order.
  task automatic mon(input int k);
    logic rst, req, gnt, v, rdy;
    logic [DW-1:0] d, e;
    int sz, depth;
    rst   = (k == 0) ? rst_a : rst_b;
    req   = (k == 0) ? req_a : req_b;
    gnt   = (k == 0) ? gnt_a : gnt_b;
    v     = (k == 0) ? rsp_valid_a : rsp_valid_b;
    rdy   = (k == 0) ? rsp_ready_a : rsp_ready_b;
    d     = (k == 0) ? rsp_rdata_a : rsp_rdata_b;
    sz    = (k == 0) ? exp_q0.size() : exp_q1.size();
    depth = (k == 0) ? 2 : 3;
    if (!rst) begin
      chk("gnt_in_reset", k, 32'(gnt), 32'd0);
      chk("valid_in_reset", k, 32'(v), 32'd0);
      prev_hold[k] = 1'b0;
    end else begin
      chk("gnt_rule", k, 32'(gnt), 32'(req && (sz < depth)));
      if (gnt) gcnt[k]++;
      chk("rsp_valid", k, 32'(v), 32'(sz != 0));
      if (prev_hold[k]) begin
        chk("hold_valid", k, 32'(v), 32'd1);
        chk("hold_data", k, d, prev_d[k]);
      end
      if (v && rdy && sz > 0) begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("rsp_data", k, d, e);
      end
      prev_hold[k] = v & ~rdy;
      prev_d[k]    = d;
    end
  endtask

  initial begin
    gcnt[0] = 0; gcnt[1] = 0;
    prev_hold[0] = 1'b0; prev_hold[1] = 1'b0;
    prev_d[0] = '0; prev_d[1] = '0;
  end

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input logic r, input logic [AW-1:0] a,
                       input logic w, input logic [DW-1:0] wd, input logic [3:0] b);
    if (k == 0) begin
      req_a = r; addr_a = a; wen_a = w; wdata_a = wd; be_a = b;
    end else begin
      req_b = r; addr_b = a; wen_b = w; wdata_b = wd; be_b = b;
    end
  endtask

  // Holds the request until granted; the expected response enters the queue
  // at the edge that accepts it. Leaves req asserted for back-to-back use.
  task automatic issue(input int k, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] wd, input logic [3:0] b,
                       input logic [DW-1:0] e, output int gc);
    int   waited;
    logic got, g;
    waited = 0;
    got    = 1'b0;
    gc     = -1;
    drive(k, 1'b1, a, w, wd, b);
    while (!got && waited < 40) begin
      @(negedge clk);
      g = (k == 0) ? gnt_a : gnt_b;
      if (g) begin
        got = 1'b1;
        gc  = cyc;
      end
      @(posedge clk);
      if (got) begin
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
      #1;
      if (rand_rdy && k == 1) rsp_ready_b = 1'($urandom_range(0, 1));
      waited++;
    end
    chk("grant_seen", k, 32'(got), 32'd1);
  endtask

  task automatic idle(input int k, input int n);
    drive(k, 1'b0, '0, 1'b0, '0, '0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int g0, g15, gtmp;
  int bp_gc [4];
  int gbase;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    drive(0, 1'b0, '0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b1; rst_b = 1'b1;

    // Reset values of the outputs with no request pending
    @(negedge clk);
    chk("rst_valid", 0, 32'(rsp_valid_a), 32'd0);
    chk("rst_gnt", 0, 32'(gnt_a), 32'd0);
    chk("rst_sram_req", 0, 32'(sram_req_a), 32'd0);
    chk("rst_rdata", 0, rsp_rdata_a, 32'd0);
    chk("rst_valid", 1, 32'(rsp_valid_b), 32'd0);
    @(posedge clk);
    #1;

    // Single read of word 5
    rsp_ready_a = 1'b1;
    issue(0, 10'd5, 1'b0, '0, 4'hF, 32'hDEADBEEF, gtmp);
    idle(0, 3);

    // Streaming: 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      issue(0, 10'(i), 1'b0, '0, 4'hF, exp_init(i), gtmp);
      if (i == 0)  g0 = gtmp;
      if (i == 15) g15 = gtmp;
    end
    idle(0, 3);
    chk("stream_span", 0, 32'(g15 - g0), 32'd15);

    // Back-pressure with depth 2: ready raised 5 cycles after the first grant
    rsp_ready_a = 1'b0;
    gbase = gcnt[0];
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          issue(0, 10'(i), 1'b0, '0, 4'hF, exp_init(i), gtmp);
          bp_gc[i] = gtmp;
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_grants", 0, 32'(gcnt[0] - gbase), 32'd2);
        rsp_ready_a = 1'b1;
      end
    join
    idle(0, 4);
    chk("bp_third_grant", 0, 32'(bp_gc[2] - bp_gc[0]), 32'd6);

    // Write with partial byte enables, then read back
    issue(0, 10'd3, 1'b1, 32'h12345678, 4'b0011, 32'h0, gtmp);
    issue(0, 10'd3, 1'b0, '0, 4'hF, 32'hFFFF5678, gtmp);
    idle(0, 4);

    // Wrap-around with depth 3 and random ready
    rand_rdy = 1'b1;
    rsp_ready_b = 1'b1;
    for (int i = 0; i < 100; i++)
      issue(1, 10'(i % 64), 1'b0, '0, 4'hF, exp_init(i % 64), gtmp);
    rand_rdy = 1'b0;
    rsp_ready_b = 1'b1;
    idle(1, 8);

    // Reset mid-operation: two queued, one in flight
    rsp_ready_b = 1'b0;
    issue(1, 10'd7, 1'b0, '0, 4'hF, exp_init(7), gtmp);
    issue(1, 10'd8, 1'b0, '0, 4'hF, exp_init(8), gtmp);
    issue(1, 10'd9, 1'b0, '0, 4'hF, exp_init(9), gtmp);
    drive(1, 1'b0, '0, 1'b0, '0, '0);
    rst_b = 1'b0;
    @(posedge clk);
    exp_q1.delete();
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 1, 32'(rsp_valid_b), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready_b = 1'b1;
    idle(1, 2);
    issue(1, 10'd10, 1'b0, '0, 4'hF, exp_init(10), gtmp);
    idle(1, 4);

    chk("drain", 0, 32'(exp_q0.size()), 32'd0);
    chk("drain", 1, 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
